// File: rtl/scaler_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scaler_cfg_ctrl
//  Purpose  : Frame-synchronous configuration controller for the bicubic
//             scaler. Host-written H/V steps are held as pending values. The
//             input frame geometry is measured from de_i/hs_i/vs_i. The
//             vertical-stage line size is computed with a sequential divider.
//             Steps and line size are committed together at the next frame
//             start.
//  Ports    : clk, rst                    clock, async active-high reset
//             cfg_h_step/cfg_v_step/cfg_wr host step write (1-cycle strobe)
//             de_i, hs_i, vs_i             input video timing (monitor only)
//             reg_h/v_scale_step           committed steps to the scaler
//             reg_v_scale_inline_size      committed V-stage line size - 1
//             cfg_pending_o, cfg_valid_o   configuration status flags
//             frame_start_o                1-cycle pulse after a vs_i rise
//             in_width_o, in_height_o      last measured frame geometry
//             err_o                        sticky zero-step write error
//  Revision : 1.0 - initial release
// ============================================================================
module scaler_cfg_ctrl #(
   parameter int LINE_IN_SIZE_MAX = 1024,
   parameter int SCALE_STEP       = 128,
   parameter int STEP_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STEP_WIDTH-1:0] cfg_h_step,
   input  logic [STEP_WIDTH-1:0] cfg_v_step,
   input  logic                  cfg_wr,
   input  logic                  de_i,
   input  logic                  hs_i,
   input  logic                  vs_i,
   output logic [STEP_WIDTH-1:0] reg_h_scale_step,
   output logic [STEP_WIDTH-1:0] reg_v_scale_step,
   output logic [STEP_WIDTH-1:0] reg_v_scale_inline_size,
   output logic                  cfg_pending_o,
   output logic                  cfg_valid_o,
   output logic                  frame_start_o,
   output logic [STEP_WIDTH-1:0] in_width_o,
   output logic [STEP_WIDTH-1:0] in_height_o,
   output logic                  err_o
);

   localparam int CNT_W      = $clog2(LINE_IN_SIZE_MAX) + 1;
   localparam int STEP_SHIFT = $clog2(SCALE_STEP);
   localparam logic [STEP_WIDTH-1:0] C_STEP_RST   = STEP_WIDTH'(SCALE_STEP);
   localparam logic [STEP_WIDTH-1:0] C_INLINE_RST = STEP_WIDTH'(LINE_IN_SIZE_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  vs_d1_q, vs_d1_d;
   logic                  hs_d1_q, hs_d1_d;
   logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
   logic                  first_line_q, first_line_d;
   logic [CNT_W-1:0]      held_width_q, held_width_d;
   logic [CNT_W-1:0]      width_q, width_d;
   logic [CNT_W-1:0]      height_q, height_d;
   logic [STEP_WIDTH-1:0] pend_h_q, pend_h_d;
   logic [STEP_WIDTH-1:0] pend_v_q, pend_v_d;
   logic [STEP_WIDTH-1:0] act_h_q, act_h_d;
   logic [STEP_WIDTH-1:0] act_v_q, act_v_d;
   logic [STEP_WIDTH-1:0] inline_q, inline_d;
   logic                  pending_q, pending_d;
   logic                  valid_q, valid_d;
   logic                  fs_q, fs_d;
   logic                  err_q, err_d;
   logic [STEP_WIDTH-1:0] div_q, div_d;
   logic [STEP_WIDTH-1:0] rem_q, rem_d;
   logic [31:0]           dvd_q, dvd_d;
   logic [4:0]            bit_cnt_q, bit_cnt_d;

   logic                  vs_rise, vs_fall, hs_rise, hs_fall;
   logic                  wr_ok, meas_ok, start_div;
   logic [CNT_W-1:0]      width_sel;
   logic [STEP_WIDTH-1:0] step_nxt_h, step_nxt_v, quo_sat;
   logic [STEP_WIDTH:0]   rem_sh, rem_sub;
   logic                  rem_ge;

   always_comb begin
      vs_rise = vs_i & ~vs_d1_q;
      vs_fall = ~vs_i & vs_d1_q;
      hs_rise = hs_i & ~hs_d1_q;
      hs_fall = ~hs_i & hs_d1_q;
      wr_ok   = cfg_wr && (cfg_h_step != '0) && (cfg_v_step != '0);

      // A line ends on hs_i rise; pix_cnt_q then holds the de count of that line.
      meas_ok   = hs_rise && (pix_cnt_q != '0);
      width_sel = meas_ok ? pix_cnt_q : held_width_q;

      step_nxt_h = pending_q ? pend_h_q : act_h_q;
      step_nxt_v = pending_q ? pend_v_q : act_v_q;
      quo_sat    = (|dvd_q[31:STEP_WIDTH]) ? '1 : dvd_q[STEP_WIDTH-1:0];

      // Restoring divider: the dividend register shifts out dividend bits at
      // the top and shifts in quotient bits at the bottom.
      rem_sh  = {rem_q, dvd_q[31]};
      rem_ge  = (rem_sh >= {1'b0, div_q});
      rem_sub = rem_sh - {1'b0, div_q};

      start_div = (wr_ok && (width_sel != '0)) ||
                  (meas_ok && ((pix_cnt_q != held_width_q) ||
                               ((state_q == ST_IDLE) && first_line_q)));

      vs_d1_d      = vs_i;
      hs_d1_d      = hs_i;
      fs_d         = vs_rise;
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = (vs_rise ? '0 : line_cnt_q) + CNT_W'(vs_i & hs_fall);
      first_line_d = first_line_q;
      held_width_d = width_sel;
      width_d      = width_q;
      height_d     = height_q;
      pend_h_d     = pend_h_q;
      pend_v_d     = pend_v_q;
      act_h_d      = act_h_q;
      act_v_d      = act_v_q;
      inline_d     = inline_q;
      pending_d    = pending_q;
      valid_d      = valid_q;
      err_d        = err_q;
      div_d        = div_q;
      rem_d        = rem_q;
      dvd_d        = dvd_q;
      bit_cnt_d    = bit_cnt_q;

      if (hs_fall)
         pix_cnt_d = CNT_W'(de_i);
      else if (!hs_i && de_i)
         pix_cnt_d = pix_cnt_q + CNT_W'(1);

      if (hs_rise) begin
         width_d      = pix_cnt_q;
         first_line_d = 1'b0;
      end
      if (vs_rise)
         first_line_d = 1'b1;
      if (vs_fall)
         height_d = line_cnt_q;

      if (state_q == ST_DIV) begin
         rem_d     = rem_ge ? rem_sub[STEP_WIDTH-1:0] : rem_sh[STEP_WIDTH-1:0];
         dvd_d     = {dvd_q[30:0], rem_ge};
         bit_cnt_d = bit_cnt_q + 5'd1;
         if (bit_cnt_q == 5'd31)
            state_d = ST_READY;
      end

      // Commit uses the values from before any same-cycle write.
      if (vs_rise && (state_q == ST_READY)) begin
         act_h_d   = step_nxt_h;
         act_v_d   = step_nxt_v;
         inline_d  = quo_sat;
         pending_d = 1'b0;
         valid_d   = 1'b1;
         state_d   = ST_IDLE;
      end

      if (cfg_wr) begin
         err_d = !wr_ok;
         if (wr_ok) begin
            pend_h_d  = cfg_h_step;
            pend_v_d  = cfg_v_step;
            pending_d = 1'b1;
            state_d   = ST_IDLE;   // abort; restarted below if a width is known
         end
      end

      if (start_div) begin
         state_d   = ST_DIV;
         div_d     = wr_ok ? cfg_h_step : step_nxt_h;
         dvd_d     = (32'(width_sel) - 32'd1) << STEP_SHIFT;
         rem_d     = '0;
         bit_cnt_d = 5'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vs_d1_q      <= 1'b0;
         hs_d1_q      <= 1'b0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         first_line_q <= 1'b0;
         held_width_q <= '0;
         width_q      <= '0;
         height_q     <= '0;
         pend_h_q     <= C_STEP_RST;
         pend_v_q     <= C_STEP_RST;
         act_h_q      <= C_STEP_RST;
         act_v_q      <= C_STEP_RST;
         inline_q     <= C_INLINE_RST;
         pending_q    <= 1'b0;
         valid_q      <= 1'b0;
         fs_q         <= 1'b0;
         err_q        <= 1'b0;
         div_q        <= C_STEP_RST;
         rem_q        <= '0;
         dvd_q        <= '0;
         bit_cnt_q    <= 5'd0;
      end else begin
         state_q      <= state_d;
         vs_d1_q      <= vs_d1_d;
         hs_d1_q      <= hs_d1_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         first_line_q <= first_line_d;
         held_width_q <= held_width_d;
         width_q      <= width_d;
         height_q     <= height_d;
         pend_h_q     <= pend_h_d;
         pend_v_q     <= pend_v_d;
         act_h_q      <= act_h_d;
         act_v_q      <= act_v_d;
         inline_q     <= inline_d;
         pending_q    <= pending_d;
         valid_q      <= valid_d;
         fs_q         <= fs_d;
         err_q        <= err_d;
         div_q        <= div_d;
         rem_q        <= rem_d;
         dvd_q        <= dvd_d;
         bit_cnt_q    <= bit_cnt_d;
      end
   end

   assign reg_h_scale_step        = act_h_q;
   assign reg_v_scale_step        = act_v_q;
   assign reg_v_scale_inline_size = inline_q;
   assign cfg_pending_o           = pending_q;
   assign cfg_valid_o             = valid_q;
   assign frame_start_o           = fs_q;
   assign in_width_o              = STEP_WIDTH'(width_q);
   assign in_height_o             = STEP_WIDTH'(height_q);
   assign err_o                   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_scaler_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scaler_cfg_ctrl
//  Purpose  : Directed self-checking bench for scaler_cfg_ctrl. Frames use
//             short heights (a few lines) to keep run time small.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scaler_cfg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cfg_h_step, cfg_v_step;
   logic        cfg_wr, de_i, hs_i, vs_i;
   logic [15:0] reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size;
   logic        cfg_pending_o, cfg_valid_o, frame_start_o, err_o;
   logic [15:0] in_width_o, in_height_o;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   scaler_cfg_ctrl #(
      .LINE_IN_SIZE_MAX (1024),
      .SCALE_STEP       (128),
      .STEP_WIDTH       (16)
   ) u_dut (
      .clk                     (clk),
      .rst                     (rst),
      .cfg_h_step              (cfg_h_step),
      .cfg_v_step              (cfg_v_step),
      .cfg_wr                  (cfg_wr),
      .de_i                    (de_i),
      .hs_i                    (hs_i),
      .vs_i                    (vs_i),
      .reg_h_scale_step        (reg_h_scale_step),
      .reg_v_scale_step        (reg_v_scale_step),
      .reg_v_scale_inline_size (reg_v_scale_inline_size),
      .cfg_pending_o           (cfg_pending_o),
      .cfg_valid_o             (cfg_valid_o),
      .frame_start_o           (frame_start_o),
      .in_width_o              (in_width_o),
      .in_height_o             (in_height_o),
      .err_o                   (err_o)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input int w);
      hs_i = 1'b0; tick(1);
      de_i = 1'b1; tick(w);
      de_i = 1'b0; tick(1);
      hs_i = 1'b1; tick(2);
   endtask

   task automatic lines(input int n, input int w);
      for (int i = 0; i < n; i++) line(w);
   endtask

   task automatic cfg_write(input logic [15:0] h, input logic [15:0] v);
      cfg_h_step = h; cfg_v_step = v; cfg_wr = 1'b1;
      tick(1);
      cfg_wr = 1'b0;
   endtask

   task automatic begin_frame();
      vs_i = 1'b1; tick(1);
   endtask

   task automatic end_frame();
      vs_i = 1'b0; tick(3);
   endtask

   task automatic check_cfg(input string tag, input int h, input int v, input int sz, input int pend);
      check_value({tag, "_h"},    reg_h_scale_step, h);
      check_value({tag, "_v"},    reg_v_scale_step, v);
      check_value({tag, "_size"}, reg_v_scale_inline_size, sz);
      check_value({tag, "_pend"}, cfg_pending_o, pend);
   endtask

   initial begin
      rst = 1'b1; cfg_h_step = '0; cfg_v_step = '0; cfg_wr = 1'b0;
      de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);

      // Reset state
      check_cfg("rst", 128, 128, 1023, 0);
      check_value("rst_valid", cfg_valid_o, 0);
      check_value("rst_err",   err_o, 0);
      check_value("rst_width", in_width_o, 0);
      check_value("rst_fs",    frame_start_o, 0);

      // 179/179 then two 600-wide frames of 4 lines
      cfg_write(179, 179);
      check_value("wr1_pend", cfg_pending_o, 1);
      begin_frame();
      check_value("f1_fs",    frame_start_o, 1);
      check_value("f1_valid", cfg_valid_o, 0);
      check_cfg("f1", 128, 128, 1023, 1);
      tick(1);
      check_value("f1_fs_low", frame_start_o, 0);
      lines(4, 600);
      end_frame();
      check_value("f1_width",  in_width_o, 600);
      check_value("f1_height", in_height_o, 4);
      begin_frame();
      check_cfg("f2", 179, 179, 428, 0);
      check_value("f2_valid", cfg_valid_o, 1);

      // Zero step rejected, then 256/256 pending mid frame
      lines(2, 600);
      cfg_write(0, 5);
      check_value("zero_err", err_o, 1);
      check_cfg("zero", 179, 179, 428, 0);
      cfg_write(256, 256);
      check_value("wr2_err", err_o, 0);
      lines(2, 600);
      check_cfg("f2_mid", 179, 179, 428, 1);
      end_frame();
      begin_frame();
      check_cfg("f3", 256, 256, 299, 0);

      // Write just before the frame start: divider not finished, no commit
      lines(4, 600);
      end_frame();
      cfg_write(179, 179);
      begin_frame();
      check_cfg("f4", 256, 256, 299, 1);
      lines(4, 400);
      end_frame();
      check_value("f4_width", in_width_o, 400);

      // Write coinciding with vs rise: commit uses previous result
      vs_i = 1'b1; cfg_h_step = 128; cfg_v_step = 128; cfg_wr = 1'b1;
      tick(1);
      cfg_wr = 1'b0;
      check_cfg("f5", 179, 179, 285, 1);
      lines(2, 400);
      end_frame();
      begin_frame();
      check_cfg("f6", 128, 128, 399, 0);

      // Reset during a divide
      line(400);
      cfg_write(200, 200);
      tick(5);
      rst = 1'b1;
      #1;
      check_cfg("mid_rst", 128, 128, 1023, 0);
      check_value("mid_rst_valid", cfg_valid_o, 0);
      check_value("mid_rst_width", in_width_o, 0);
      tick(1);
      rst = 1'b0;
      tick(1);
      end_frame();
      begin_frame();
      check_value("r1_valid", cfg_valid_o, 0);
      lines(2, 400);
      end_frame();
      check_value("r1_height", in_height_o, 2);
      begin_frame();
      check_cfg("r2", 128, 128, 399, 0);
      check_value("r2_valid", cfg_valid_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
